// File: rtl/ser_pkg.sv
// Shared types and helpers for the data serializer.
package ser_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Counter width for n words; a single-word frame still needs one bit.
    function automatic int CNT_W(input int n);
        int w;
        if (n <= 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/data_serializer.sv
// Parallel-to-serial frame replay: STAGE words in, one word per clock out,
// framed by start on word 0 and last on word STAGE-1. Back-to-back frames
// are gapless because a new frame is accepted while the final word is out.
module data_serializer
    import ser_pkg::*;
#(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] data_p [0:STAGE-1],
    output logic              ready,
    output logic              start,
    output logic [DWIDTH-1:0] data,
    output logic              valid,
    output logic              last
);

    localparam int                CW           = CNT_W(STAGE);
    localparam logic [CW-1:0]     CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE      = CW'(1'b1);
    localparam logic [CW-1:0]     CNT_LAST     = CW'(STAGE - 32'sd1);
    localparam logic [DWIDTH-1:0] WORD_ZERO    = {DWIDTH{1'b0}};
    localparam logic              LAST_ON_LOAD = (STAGE == 32'sd1);

    ser_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] buf_q [0:STAGE-1];
    logic [DWIDTH-1:0] buf_d [0:STAGE-1];
    logic [DWIDTH-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              last_q, last_d;

    logic [CW-1:0]     nxt_idx_s;
    logic [DWIDTH-1:0] rd_word_s;
    logic              ready_s;
    logic              accept_s;

    // Select the buffered word that follows the one currently on the line.
    always_comb begin
        nxt_idx_s = cnt_q + CNT_ONE;
        rd_word_s = WORD_ZERO;
        for (int i = 0; i < STAGE; i++) begin
            rd_word_s = rd_word_s | ((nxt_idx_s == CW'(i)) ? buf_q[i] : WORD_ZERO);
        end
    end

    // Ready when idle or while the final word of the current frame is out.
    always_comb begin
        ready_s  = (state_q == IDLE) || ((state_q == SEND) && (cnt_q == CNT_LAST));
        accept_s = load & ready_s;
    end

    // Next-state and next-output logic; outputs fall to zero unless a word is due.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = WORD_ZERO;
        valid_d = 1'b0;
        start_d = 1'b0;
        last_d  = 1'b0;
        if (accept_s) begin
            buf_d   = data_p;
            data_d  = data_p[0];
            valid_d = 1'b1;
            start_d = 1'b1;
            last_d  = LAST_ON_LOAD;
            cnt_d   = CNT_ZERO;
            state_d = SEND;
        end else begin
            case (state_q)
                SEND: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d   = nxt_idx_s;
                        data_d  = rd_word_s;
                        valid_d = 1'b1;
                        last_d  = (nxt_idx_s == CNT_LAST);
                    end else begin
                        cnt_d   = CNT_ZERO;
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, buffer and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            for (int i = 0; i < STAGE; i++) begin
                buf_q[i] <= WORD_ZERO;
            end
            data_q  <= WORD_ZERO;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            last_q  <= last_d;
        end
    end

    assign ready = ready_s;
    assign start = start_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign last  = last_q;

endmodule
